graycode_cfg_ctrl: RTL
======================

GRAYCODE_CFG_CTRL -- requirements
Module: graycode_cfg_ctrl

Interface
REQ-001 Parameter SYNC_STAGES, 2, synchronizer depth for cs/sck/sdi (legal 2..3).
REQ-002 Parameter FRAME_BITS, 12, SPI write-frame length in bits (fixed value, not to be overridden).
REQ-003 clk  input  1  system clock; all logic on rising edge; one clock domain.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 cs  input  1  SPI chip select, active-low, asynchronous to clk.
REQ-006 sck  input  1  SPI clock, mode 0, data sampled on sck rising edge, asynchronous to clk.
REQ-007 sdi  input  1  SPI serial data, MSB first.
REQ-008 cfg_max  output  5  counter terminal value.
REQ-009 cfg_wrap  output  1  counter wrap enable.
REQ-010 cfg_pwm_en  output  1  PWM output enable.
REQ-011 cfg_tx_en  output  1  serial TX enable.
REQ-012 cfg_dir_inv  output  1  invert direction sense.
REQ-013 cfg_debounce  output  4  channel debounce length in clk cycles.
REQ-014 cfg_tx_div  output  8  serial TX baud divider.
REQ-015 cfg_update  output  1  one-cycle pulse, the cycle a register changes.
REQ-016 frame_err  output  1  one-cycle pulse on rejected frame.
REQ-017 busy  output  1  high while a frame is in progress (state SHIFT or COMMIT).

Function
REQ-018 Frame format: bits [11:8] address, [7:0] data, MSB first.
REQ-019 cs, sck, sdi SHALL each pass through SYNC_STAGES flops before use; sck rise and cs fall/rise SHALL be detected from synchronized values.
REQ-020 FSM states: IDLE, SHIFT, COMMIT.
REQ-021 IDLE -> SHIFT on synchronized cs falling edge; bit counter cleared, shift register cleared.
REQ-022 In SHIFT, each synchronized sck rise shifts sdi into the LSB and increments the bit counter; the counter saturates at 13 to mark overflow.
REQ-023 SHIFT -> COMMIT on synchronized cs rising edge; a cs rise and an sck rise detected in the same cycle: cs rise wins, sck edge discarded.
REQ-024 COMMIT lasts exactly one cycle, then -> IDLE.
REQ-025 In COMMIT with count == 12 and address 0..3: write register, assert cfg_update in that same cycle, new value visible on outputs in the next cycle.
REQ-026 Address 0: cfg_max = data[4:0]; data[4:0] == 0 stored as 1.
REQ-027 Address 1: data[0] cfg_wrap, data[1] cfg_pwm_en, data[2] cfg_tx_en, data[3] cfg_dir_inv; data[7:4] ignored.
REQ-028 Address 2: cfg_debounce = data[3:0]. Address 3: cfg_tx_div = data; data == 0 stored as 1.
REQ-029 In COMMIT with count 1..11, count 13 (overflow) or address 4..15: no register change, frame_err pulses one cycle.
REQ-030 In COMMIT with count 0 (cs toggled, no sck): neither cfg_update nor frame_err.
REQ-031 sck edges while in IDLE SHALL be ignored.

Reset
REQ-032 rst SHALL force: state IDLE, cfg_max 31, cfg_wrap 1, cfg_pwm_en 0, cfg_tx_en 0, cfg_dir_inv 0, cfg_debounce 2, cfg_tx_div 100, cfg_update 0, frame_err 0, busy 0, counters and shift register 0.
REQ-033 Synchronizer flops SHALL reset to idle levels (cs 1, sck 0, sdi 0).
REQ-034 rst during SHIFT SHALL abandon the frame with no write and no frame_err; a cs rise after reset release SHALL NOT produce a commit.

Structure
REQ-035 Package graycode_cfg_pkg SHALL hold the FSM state enum, address constants (ADDR_MAX 0, ADDR_CTRL 1, ADDR_DEB 2, ADDR_TXDIV 3), all reset values and FRAME_BITS.
REQ-036 One sub-module, graycode_cfg_sync: SYNC_STAGES synchronizer plus rise/fall detect for one bit, instantiated three times.

Verification
REQ-037 Reset release -> outputs equal REQ-032 values, busy 0.
REQ-038 Write addr 0, data 0x0A (frame 0x00A) -> cfg_update one pulse, cfg_max 10 next cycle, other outputs unchanged.
REQ-039 Write addr 1, data 0x06 -> cfg_pwm_en 1, cfg_tx_en 1, cfg_wrap 0, cfg_dir_inv 0; then addr 3, data 0x00 -> cfg_tx_div 1.
REQ-040 11-bit frame, then 13-bit frame, then addr 5 frame -> three frame_err pulses, no cfg_update, registers unchanged.
REQ-041 cs low/high with no sck -> busy pulses, no cfg_update, no frame_err; sck toggling with cs high -> no effect.
REQ-042 rst asserted after 6 bits of an addr-2 frame, cs raised after release -> cfg_debounce 2, no cfg_update, no frame_err.

Source files
------------

// File: rtl/graycode_cfg_pkg.sv
// rtl/graycode_cfg_pkg.sv - shared types, addresses and reset values for the SPI config block
package graycode_cfg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } state_e;

    localparam int FRAME_BITS = 12;

    // Bit counter saturates here so frames longer than FRAME_BITS stay distinguishable.
    localparam logic [3:0] CNT_OVF = 4'd13;

    localparam logic [3:0] ADDR_MAX   = 4'd0;
    localparam logic [3:0] ADDR_CTRL  = 4'd1;
    localparam logic [3:0] ADDR_DEB   = 4'd2;
    localparam logic [3:0] ADDR_TXDIV = 4'd3;

    localparam logic [4:0] RST_MAX      = 5'd31;
    localparam logic       RST_WRAP     = 1'b1;
    localparam logic       RST_PWM_EN   = 1'b0;
    localparam logic       RST_TX_EN    = 1'b0;
    localparam logic       RST_DIR_INV  = 1'b0;
    localparam logic [3:0] RST_DEBOUNCE = 4'd2;
    localparam logic [7:0] RST_TX_DIV   = 8'd100;

endpackage

// File: rtl/graycode_cfg_sync.sv
// rtl/graycode_cfg_sync.sv - multi-flop synchronizer with rise/fall detect for one bit
// Ports:
//   clk_i, rst_i : clock, synchronous active-high reset
//   d_i          : asynchronous input
//   q_o          : synchronized level
//   rise_o/fall_o: one-cycle edge pulses from the synchronized level
module graycode_cfg_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;
    // Edges are suppressed until the chain holds only post-reset samples, so an
    // input that sat away from its idle level across reset cannot fake an edge.
    logic [STAGES:0]   prime_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q  <= {STAGES{RESET_VAL}};
            prev_q  <= RESET_VAL;
            prime_q <= '0;
        end else begin
            sync_q  <= {sync_q[STAGES-2:0], d_i};
            prev_q  <= sync_q[STAGES-1];
            prime_q <= {prime_q[STAGES-1:0], 1'b1};
        end
    end

    assign q_o    = sync_q[STAGES-1];
    assign rise_o = prime_q[STAGES] &  sync_q[STAGES-1] & ~prev_q;
    assign fall_o = prime_q[STAGES] & ~sync_q[STAGES-1] &  prev_q;

endmodule

// File: rtl/graycode_cfg_ctrl.sv
// rtl/graycode_cfg_ctrl.sv - SPI write-only configuration register block
// Ports:
//   clk_i, rst_i        : clock, synchronous active-high reset
//   cs_i, sck_i, sdi_i  : SPI mode 0 slave inputs (asynchronous), 12-bit frames {addr[3:0], data[7:0]}
//   cfg_*_o             : configuration register outputs
//   cfg_update_o        : pulse in the commit cycle of an accepted write
//   frame_err_o         : pulse in the commit cycle of a rejected frame
//   busy_o              : high while a frame is being shifted or committed
module graycode_cfg_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int FRAME_BITS  = graycode_cfg_pkg::FRAME_BITS
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       cs_i,
    input  logic       sck_i,
    input  logic       sdi_i,
    output logic [4:0] cfg_max_o,
    output logic       cfg_wrap_o,
    output logic       cfg_pwm_en_o,
    output logic       cfg_tx_en_o,
    output logic       cfg_dir_inv_o,
    output logic [3:0] cfg_debounce_o,
    output logic [7:0] cfg_tx_div_o,
    output logic       cfg_update_o,
    output logic       frame_err_o,
    output logic       busy_o
);

    import graycode_cfg_pkg::*;

    logic cs_rise, cs_fall, sck_rise, sdi_s;
    logic cs_lvl_unused, sck_lvl_unused, sck_fall_unused, sdi_rise_unused, sdi_fall_unused;

    graycode_cfg_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .clk_i(clk_i), .rst_i(rst_i), .d_i(cs_i),
        .q_o(cs_lvl_unused), .rise_o(cs_rise), .fall_o(cs_fall)
    );
    graycode_cfg_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
        .clk_i(clk_i), .rst_i(rst_i), .d_i(sck_i),
        .q_o(sck_lvl_unused), .rise_o(sck_rise), .fall_o(sck_fall_unused)
    );
    graycode_cfg_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sdi (
        .clk_i(clk_i), .rst_i(rst_i), .d_i(sdi_i),
        .q_o(sdi_s), .rise_o(sdi_rise_unused), .fall_o(sdi_fall_unused)
    );

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [11:0] shift_q, shift_d;

    logic [3:0]  addr;
    logic [7:0]  data;
    assign addr = shift_q[11:8];
    assign data = shift_q[7:0];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            shift_q        <= '0;
            cfg_max_o      <= RST_MAX;
            cfg_wrap_o     <= RST_WRAP;
            cfg_pwm_en_o   <= RST_PWM_EN;
            cfg_tx_en_o    <= RST_TX_EN;
            cfg_dir_inv_o  <= RST_DIR_INV;
            cfg_debounce_o <= RST_DEBOUNCE;
            cfg_tx_div_o   <= RST_TX_DIV;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            if (cfg_update_o) begin
                case (addr)
                    ADDR_MAX:   cfg_max_o <= (data[4:0] == 5'd0) ? 5'd1 : data[4:0];
                    ADDR_CTRL: begin
                        cfg_wrap_o    <= data[0];
                        cfg_pwm_en_o  <= data[1];
                        cfg_tx_en_o   <= data[2];
                        cfg_dir_inv_o <= data[3];
                    end
                    ADDR_DEB:   cfg_debounce_o <= data[3:0];
                    ADDR_TXDIV: cfg_tx_div_o   <= (data == 8'd0) ? 8'd1 : data;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_d = ST_SHIFT;
                    cnt_d   = '0;
                    shift_d = '0;
                end
            end
            ST_SHIFT: begin
                // A cs rise ends the frame even if an sck edge lands in the same cycle.
                if (cs_rise) begin
                    state_d = ST_COMMIT;
                end else if (sck_rise) begin
                    shift_d = {shift_q[10:0], sdi_s};
                    if (cnt_q != CNT_OVF) begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            ST_COMMIT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cfg_update_o = 1'b0;
        frame_err_o  = 1'b0;
        busy_o       = (state_q != ST_IDLE);
        if (state_q == ST_COMMIT) begin
            cfg_update_o = (cnt_q == 4'(FRAME_BITS)) && (addr <= ADDR_TXDIV);
            // An empty frame (cs toggled with no sck) is silently dropped.
            frame_err_o  = (cnt_q != 4'd0) && !cfg_update_o;
        end
    end

endmodule
